// File: rtl/ocs_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ocs_cfg_pkg
//  Description : Shared definitions for the OCS reconfiguration path:
//                controller FSM state encodings, the index-width helper used
//                across the OCS datapath, and the identity-map generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ocs_cfg_pkg;

    // Widest map any supported configuration needs (16 ports x 4-bit index).
    localparam int C_MAP_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_APPLY    = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_ACTIVE   = 3'd5
    } cfg_state_t;

    // Bits needed to name one port; never less than one bit.
    function automatic int idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Map where field j holds j. Built bit by bit so the field width can be
    // a run-time argument; callers truncate to their own map width.
    function automatic logic [C_MAP_MAX_W-1:0] identity_map(input int ports);
        logic [C_MAP_MAX_W-1:0] m;
        int                     w;
        m = '0;
        w = idx_width(ports);
        for (int b = 0; b < C_MAP_MAX_W; b++) begin
            if (b < ports * w) begin
                m[b] = 1'(((b / w) >> (b % w)) & 1);
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocs_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ocs_req_fifo
//  Description : Synchronous single-clock request FIFO with occupancy level.
//                Push while full and pop while empty are ignored; a push and
//                pop in the same cycle are both honoured.
//  Ports       : i_clk, i_rst (sync, active-high)
//                i_push/i_data  - write side
//                i_pop/o_data   - read side, o_data shows the head (FWFT)
//                o_full, o_empty, o_level - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module ocs_req_fifo #(
    parameter  int P_WIDTH = 8,
    parameter  int P_DEPTH = 4,
    localparam int P_PTR_W = $clog2(P_DEPTH),
    localparam int P_LVL_W = $clog2(P_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [P_LVL_W-1:0] o_level
);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [P_PTR_W-1:0] r_wr_ptr;
    logic [P_PTR_W-1:0] r_rd_ptr;
    logic [P_LVL_W-1:0] r_level;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_level == P_LVL_W'(P_DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + P_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + P_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + P_LVL_W'(1);
                2'b01:   r_level <= r_level - P_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ocs_nxn_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ocs_nxn_config_ctrl
//  Description : N-port reconfiguration controller for the optical circuit
//                switch. Queues destination-permutation requests, rejects
//                non-permutations, converts accepted requests into a
//                per-output source map for the switch driver, waits for the
//                driver's config-end, applies a settle guard and then flags
//                the path active.
//  Ports       : i_clk, i_rst (sync, active-high)
//                i_req/i_req_valid/o_req_ready - request queue input; field k
//                    of i_req is the destination output of input k
//                o_cfg_map/o_cfg_valid - field j = source input for output j,
//                    valid is a one-cycle pulse per new map
//                i_config_end - driver acknowledgement pulse
//                o_cfg_active - map applied and settled
//                o_busy, o_err_perm, o_err_timeout, o_fifo_level - status
//  Revision    : 1.0 - initial release
// ============================================================================
module ocs_nxn_config_ctrl
    import ocs_cfg_pkg::*;
#(
    parameter  int P_PORTS       = 8,
    parameter  int P_FIFO_DEPTH  = 4,
    parameter  int P_SETTLE_CYC  = 16,
    parameter  int P_END_TIMEOUT = 1024,
    localparam int P_IDX_W       = idx_width(P_PORTS),
    localparam int P_MAP_W       = P_PORTS * P_IDX_W,
    localparam int P_LVL_W       = $clog2(P_FIFO_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [P_MAP_W-1:0] i_req,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    output logic [P_MAP_W-1:0] o_cfg_map,
    output logic               o_cfg_valid,
    input  logic               i_config_end,
    output logic               o_cfg_active,
    output logic               o_busy,
    output logic               o_err_perm,
    output logic               o_err_timeout,
    output logic [P_LVL_W-1:0] o_fifo_level
);

    localparam int C_CNT_MAX = (P_END_TIMEOUT > P_SETTLE_CYC) ? P_END_TIMEOUT : P_SETTLE_CYC;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam logic [P_MAP_W-1:0] C_IDENTITY = P_MAP_W'(identity_map(P_PORTS));

    cfg_state_t         r_state;
    logic               r_from_active;
    logic [P_MAP_W-1:0] r_check;
    logic [P_MAP_W-1:0] r_cfg_map;
    logic               r_cfg_valid;
    logic               r_cfg_active;
    logic               r_err_perm;
    logic               r_err_timeout;
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_ready;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [P_MAP_W-1:0] w_fifo_data;
    logic [P_PORTS-1:0] w_hit;
    logic [P_MAP_W-1:0] w_inv;
    logic               w_is_perm;
    logic               w_same_map;
    logic [C_CNT_W-1:0] w_cnt_inc;

    // Ready is forced low during reset so nothing is accepted into a FIFO
    // that is being flushed.
    assign w_ready = ~w_full & ~i_rst;
    assign w_pop   = ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) & ~w_empty;

    ocs_req_fifo #(
        .P_WIDTH (P_MAP_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_req_valid & w_ready),
        .i_data  (i_req),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // For each output j: hit[j] marks that some input targets j, and the
    // inverse map records which input that is. With P_PORTS fields into
    // P_PORTS bins, every bin is hit exactly when no destination repeats.
    for (genvar j = 0; j < P_PORTS; j++) begin : g_inv
        logic               w_hit_j;
        logic [P_IDX_W-1:0] w_src_j;
        always_comb begin
            w_hit_j = 1'b0;
            w_src_j = '0;
            for (int k = 0; k < P_PORTS; k++) begin
                if (r_check[k*P_IDX_W +: P_IDX_W] == P_IDX_W'(j)) begin
                    w_hit_j = 1'b1;
                    w_src_j = P_IDX_W'(k);
                end
            end
        end
        assign w_hit[j]                     = w_hit_j;
        assign w_inv[j*P_IDX_W +: P_IDX_W] = w_src_j;
    end

    assign w_is_perm  = &w_hit;
    assign w_same_map = (w_inv == r_cfg_map);
    assign w_cnt_inc  = (r_cnt == {C_CNT_W{1'b1}}) ? r_cnt : r_cnt + C_CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_from_active <= 1'b0;
            r_check       <= '0;
            r_cfg_map     <= C_IDENTITY;
            r_cfg_valid   <= 1'b0;
            r_cfg_active  <= 1'b0;
            r_err_perm    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_cfg_valid   <= 1'b0;
            r_err_perm    <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ACTIVE: begin
                    if (!w_empty) begin
                        r_check       <= w_fifo_data;
                        r_from_active <= (r_state == ST_ACTIVE);
                        r_cfg_active  <= 1'b0;
                        r_state       <= ST_CHECK;
                    end else if (r_state == ST_ACTIVE) begin
                        // Also restores the flag after a no-change request.
                        r_cfg_active <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!w_is_perm) begin
                        r_err_perm <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (r_from_active && w_same_map) begin
                        // Switch already holds this map; skip the driver.
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_cfg_map   <= w_inv;
                    r_cfg_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    // config_end takes priority over an expiring timeout.
                    if (i_config_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else if (r_cnt == C_CNT_W'(P_END_TIMEOUT - 1)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == C_CNT_W'(P_SETTLE_CYC - 1)) begin
                        r_cfg_active <= 1'b1;
                        r_state      <= ST_ACTIVE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = w_ready;
    assign o_cfg_map     = r_cfg_map;
    assign o_cfg_valid   = r_cfg_valid;
    assign o_cfg_active  = r_cfg_active;
    assign o_err_perm    = r_err_perm;
    assign o_err_timeout = r_err_timeout;
    assign o_busy        = ((r_state != ST_IDLE) && (r_state != ST_ACTIVE)) || !w_empty;

endmodule
`default_nettype wire
